// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and helpers for the fetch queue slice:
//                instruction width, PC step, default reset vector and a
//                ceiling-log2 used to size counters and pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          INSTR_WIDTH      = 32;
    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Smallest r such that 2**r >= value (clog2(1) = 0).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO of {instruction, pc} pairs. Head entry is
//                presented combinationally. Flush beats push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [INSTR_WIDTH-1:0]   push_instr_i,
    input  logic [PC_W-1:0]          push_pc_i,
    input  logic                     pop_i,
    output logic [clog2(DEPTH):0]    count_o,
    output logic [INSTR_WIDTH-1:0]   head_instr_o,
    output logic [PC_W-1:0]          head_pc_o
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
    logic [PC_W-1:0]        pc_q    [DEPTH];
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q,  count_d;

    logic w_do_pop;
    logic w_do_push;

    // Popping an empty queue is a no-op; a push into a full queue is only
    // accepted when a pop frees the slot in the same cycle.
    assign w_do_pop  = pop_i && (count_q != '0);
    assign w_do_push = push_i && ((count_q != CW'(DEPTH)) || w_do_pop);

    // Pointer and occupancy next-state; flush empties the queue outright.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (w_do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; entries are cleared only by reset, a flush just
    // abandons them behind the rewound pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (w_do_push && !flush_i) begin
            instr_q[wr_ptr_q] <= push_instr_i;
            pc_q[wr_ptr_q]    <= push_pc_i;
        end
    end

    assign count_o      = count_q;
    assign head_instr_o = instr_q[rd_ptr_q];
    assign head_pc_o    = pc_q[rd_ptr_q];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction fetch stage decoupled from decode by a queue.
//                Credit-limited req/gnt/rvalid fetch, in-order responses,
//                redirect flushes the queue and drops in-flight responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   PCSrcA,
    input  logic [DATA_WIDTH-1:0]  PCTargetA,
    output logic                   imem_req,
    output logic [DATA_WIDTH-1:0]  imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   ValidB,
    input  logic                   ReadyB,
    output logic [INSTR_WIDTH-1:0] InstrB,
    output logic [DATA_WIDTH-1:0]  PCB,
    output logic [DATA_WIDTH-1:0]  PCPlus4B
);

    localparam int                    CW   = clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PC_STEP);

    logic [DATA_WIDTH-1:0] pc_q,          pc_d;
    logic [DATA_WIDTH-1:0] resp_pc_q,     resp_pc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         drop_cnt_q,    drop_cnt_d;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_in_use;
    logic          w_issue;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;

    // Every queued or in-flight instruction holds a slot, so the queue can
    // never overflow whatever the memory latency.
    assign w_in_use  = {1'b0, w_count} + {1'b0, outstanding_q};
    assign imem_req  = !PCSrcA && (w_in_use < (CW + 1)'(FIFO_DEPTH));
    assign imem_addr = pc_q;
    assign w_issue   = imem_req && imem_gnt;

    // A response with nothing in flight is a protocol error and is ignored.
    assign w_rsp  = imem_rvalid && (outstanding_q != '0);
    assign w_push = w_rsp && (drop_cnt_q == '0) && !PCSrcA;
    assign w_pop  = ValidB && ReadyB;

    // Fetch PC, response PC and in-flight bookkeeping next-state.
    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(w_issue) - CW'(w_rsp);
        drop_cnt_d    = drop_cnt_q;
        if (PCSrcA) begin
            pc_d       = PCTargetA;
            resp_pc_d  = PCTargetA;
            // Everything still in flight after this edge belongs to the
            // abandoned path; a response landing now is discarded as well.
            drop_cnt_d = outstanding_q - CW'(w_rsp);
        end else begin
            if (w_issue) begin
                pc_d = pc_q + STEP;
            end
            if (w_push) begin
                resp_pc_d = resp_pc_q + STEP;
            end
            if (w_rsp && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PC_W  (DATA_WIDTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (PCSrcA),
        .push_i       (w_push),
        .push_instr_i (imem_rdata),
        .push_pc_i    (resp_pc_q),
        .pop_i        (w_pop),
        .count_o      (w_count),
        .head_instr_o (InstrB),
        .head_pc_o    (PCB)
    );

    assign ValidB   = (w_count != '0);
    assign PCPlus4B = PCB + STEP;

`ifndef SYNTHESIS
    // Memory must never return a response that was not requested.
    a_no_orphan_rvalid : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(imem_rvalid && (outstanding_q == '0))
    );
`endif

endmodule : fetch_queue
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Next-generation instruction fetch stage: decoupled from decode by a parametrised instruction queue.
- Supports a variable-latency instruction memory via a req/gnt/rvalid handshake, decode back-pressure, a configurable reset vector, and branch redirect with flush.
- Sits between the PC/branch-resolution logic (A-side) and decode (B-side).

Parameters:
- DATA_WIDTH, 32, width of PC and addresses.
- RESET_PC, 0, PC value loaded on reset.
- FIFO_DEPTH, 4, instruction queue entries; power of two, >=2; also caps in-flight requests.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- PCSrcA  in  1  redirect request; takes priority over all other activity
- PCTargetA  in  DATA_WIDTH  redirect target PC
- imem_req  out  1  fetch request valid
- imem_addr  out  DATA_WIDTH  fetch address (equals PC)
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; responses return in request order
- imem_rdata  in  32  instruction word
- ValidB  out  1  queue head valid
- ReadyB  in  1  decode consumes head this cycle (pop = ValidB & ReadyB)
- InstrB  out  32  head instruction
- PCB  out  DATA_WIDTH  head PC
- PCPlus4B  out  DATA_WIDTH  head PC + 4

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset: PC = RESET_PC, resp_pc = RESET_PC, queue empty, outstanding = 0, drop_cnt = 0, all entries = 0. Consequently ValidB = 0, InstrB/PCB = 0, PCPlus4B = 4.
- Counters: count, outstanding and drop_cnt are each clog2(FIFO_DEPTH)+1 bits wide.
- Credit: imem_req = !PCSrcA && (count + outstanding < FIFO_DEPTH). imem_addr = PC, combinational.
- Issue: on imem_req & imem_gnt, PC <= PC + 4 (mod 2^DATA_WIDTH) and outstanding increments.
- Response handling: on imem_rvalid, outstanding decrements.
  - If drop_cnt != 0, the response is discarded and drop_cnt decrements.
  - Otherwise {imem_rdata, resp_pc} is pushed to the queue and resp_pc <= resp_pc + 4.
- Queue outputs: driven combinationally from the head entry. PCPlus4B = PCB + 4, wrapping.
- Redirect (PCSrcA = 1), evaluated at the clock edge:
  - PC <= PCTargetA and resp_pc <= PCTargetA.
  - Queue is flushed: count = 0; a same-cycle pop is ignored.
  - No request is issued.
  - drop_cnt <= outstanding + drop... more precisely: drop_cnt <= outstanding - imem_rvalid, so every still-in-flight response is dropped.
  - A response arriving in the redirect cycle is discarded.
- Push and pop in the same cycle: count unchanged. Overflow cannot occur because of the credit rule. Popping an empty queue has no effect.
- Latency: with zero-wait memory (gnt = 1, rvalid exactly one cycle after grant):
  - Redirect at edge E0 → request in cycle 1 → response in cycle 2 → ValidB = 1 in cycle 3 with PCB = target.
  - Steady-state throughput: one instruction per cycle.
- Stall: ReadyB = 0 holds the head stable. Requests continue until credits are exhausted.
- imem_gnt = 0: PC and imem_addr are held and imem_req stays asserted. The request is never withdrawn except by redirect.
- Protocol errors: imem_rvalid with outstanding = 0 is a protocol error; assert it in simulation and ignore it in hardware.

Decomposition:
- fetch_pkg holds: INSTR_WIDTH = 32, PC_STEP = 4, a default RESET_PC, and a counter-width function clog2.
- One sub-module, fetch_fifo:
  - Synchronous FIFO of {instr, pc} pairs, depth FIFO_DEPTH.
  - Interface: push/pop/flush, count output, combinational head.
  - Flush has priority over push and pop.

Test Plan:
- Reset release, gnt = 1, 1-cycle rvalid, ReadyB = 1 → PCB sequence 0, 4, 8, 12 on consecutive cycles; first ValidB in cycle 3.
- ReadyB = 0 for 10 cycles, FIFO_DEPTH = 4 → exactly 4 grants, then imem_req = 0. Head holds PCB = 0; after ReadyB = 1, pops 0, 4, 8, 12 in order.
- Redirect to 0x100 with 2 requests in flight → next 2 rvalids discarded; first ValidB shows PCB = 0x100, PCPlus4B = 0x104.
- Redirect in the same cycle as rvalid and pop → queue empty next cycle; drop_cnt = outstanding - 1; no stale instruction is ever presented.
- imem_gnt random 50%, rvalid latency 1–3 cycles → PCB strictly increments by 4 and InstrB matches the memory model.
- PCTargetA = 0xFFFFFFFC → PCB sequence 0xFFFFFFFC, then 0x0; PCPlus4B = 0x0 on the first of those.
